// File: rtl/aes_key_reverse_pkg.sv
// Shared definitions for the AES round-key reversal buffer: round counts,
// key-length codes and the controller state encoding.
package aes_key_reverse_pkg;

    localparam logic [3:0] AES_NR_128 = 4'd10;
    localparam logic [3:0] AES_NR_192 = 4'd12;
    localparam logic [3:0] AES_NR_256 = 4'd14;

    localparam logic [1:0] KEY_LEN_128 = 2'b00;
    localparam logic [1:0] KEY_LEN_192 = 2'b01;
    localparam logic [1:0] KEY_LEN_256 = 2'b10;

    localparam int PTR_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_READY,
        ST_PLAY
    } rk_state_e;

    // Code 11 is not a legal AES length and falls back to the 128-bit schedule.
    function automatic logic [3:0] nr_from_len(input logic [1:0] len);
        case (len)
            KEY_LEN_192: return AES_NR_192;
            KEY_LEN_256: return AES_NR_256;
            default:     return AES_NR_128;
        endcase
    endfunction

endpackage

// File: rtl/aes_rk_store.sv
// Round-key register file: one synchronous write port, one asynchronous read port.
// Contents are not reset; the controller never reads an entry it has not written.
module aes_rk_store #(
    parameter int W     = 32,
    parameter int DEPTH = 15,
    parameter int AW    = 4
) (
    input  logic            clk,
    input  logic            we_i,
    input  logic [AW-1:0]   waddr_i,
    input  logic [4*W-1:0]  wdata_i,
    input  logic [AW-1:0]   raddr_i,
    output logic [4*W-1:0]  rdata_o
);

    logic [4*W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/aes_key_reverse.sv
// Captures the forward AES round-key stream and replays it last-round-first
// over a valid/ready handshake, keeping the schedule for repeated decryptions.
module aes_key_reverse #(
    parameter int W      = 32,
    parameter int MAX_RK = 15
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           key_flag,
    input  logic [1:0]     leng_key,
    input  logic           wi_valid,
    input  logic [W-1:0]   wi_0,
    input  logic [W-1:0]   wi_1,
    input  logic [W-1:0]   wi_2,
    input  logic [W-1:0]   wi_3,
    input  logic           dec_start,
    input  logic           rk_ready,
    output logic           rk_valid,
    output logic [4*W-1:0] rk_out,
    output logic [3:0]     rk_round,
    output logic           rk_last,
    output logic           keys_ready,
    output logic           busy
);
    import aes_key_reverse_pkg::*;

    rk_state_e        state_q, state_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [1:0]       len_q, len_d;
    logic             keys_ready_q, keys_ready_d;
    logic [3:0]       nr;
    logic             wr_en;
    logic [4*W-1:0]   rd_data;

    assign nr = nr_from_len(len_q);

    // A beat landing together with key_flag belongs to the old schedule and is dropped.
    assign wr_en = (state_q == ST_LOAD) && wi_valid && !key_flag;

    aes_rk_store #(
        .W     (W),
        .DEPTH (MAX_RK),
        .AW    (PTR_W)
    ) u_store (
        .clk     (clk),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q),
        .wdata_i ({wi_0, wi_1, wi_2, wi_3}),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            len_q        <= KEY_LEN_128;
            keys_ready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            len_q        <= len_d;
            keys_ready_q <= keys_ready_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        len_d        = len_q;
        keys_ready_d = keys_ready_q;
        if (key_flag) begin
            state_d      = ST_LOAD;
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            len_d        = leng_key;
            keys_ready_d = 1'b0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (wi_valid) begin
                        wr_ptr_d = wr_ptr_q + 4'd1;
                        if (wr_ptr_q == nr) begin
                            state_d      = ST_READY;
                            keys_ready_d = 1'b1;
                        end
                    end
                end
                ST_READY: begin
                    if (dec_start) begin
                        state_d  = ST_PLAY;
                        rd_ptr_d = nr;
                    end
                end
                ST_PLAY: begin
                    if (rk_ready) begin
                        if (rd_ptr_q == '0) begin
                            state_d = ST_READY;
                        end else begin
                            rd_ptr_d = rd_ptr_q - 4'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Playback outputs depend only on state and read pointer, so they hold under backpressure.
    always_comb begin
        rk_valid = 1'b0;
        rk_out   = '0;
        rk_round = '0;
        rk_last  = 1'b0;
        busy     = 1'b0;
        case (state_q)
            ST_LOAD: busy = 1'b1;
            ST_PLAY: begin
                busy     = 1'b1;
                rk_valid = 1'b1;
                rk_out   = rd_data;
                rk_round = rd_ptr_q;
                rk_last  = (rd_ptr_q == '0);
            end
            default: ;
        endcase
    end

    assign keys_ready = keys_ready_q;

endmodule

// File: tb/tb_aes_key_reverse.sv
// Self-checking bench for aes_key_reverse: an in-bench AES key expansion feeds
// the buffer and predicts every reversed round key.
module tb_aes_key_reverse;

    logic         clk;
    logic         rst_n;
    logic         key_flag;
    logic [1:0]   leng_key;
    logic         wi_valid;
    logic [31:0]  wi_0, wi_1, wi_2, wi_3;
    logic         dec_start;
    logic         rk_ready;
    logic         rk_valid;
    logic [127:0] rk_out;
    logic [3:0]   rk_round;
    logic         rk_last;
    logic         keys_ready;
    logic         busy;

    int checks   = 0;
    int failures = 0;
    int curNr    = 10;

    logic [127:0] rkModel [15];

    aes_key_reverse #(.W(32), .MAX_RK(15)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_flag   (key_flag),
        .leng_key   (leng_key),
        .wi_valid   (wi_valid),
        .wi_0       (wi_0),
        .wi_1       (wi_1),
        .wi_2       (wi_2),
        .wi_3       (wi_3),
        .dec_start  (dec_start),
        .rk_ready   (rk_ready),
        .rk_valid   (rk_valid),
        .rk_out     (rk_out),
        .rk_round   (rk_round),
        .rk_last    (rk_last),
        .keys_ready (keys_ready),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    // GF(2^8) arithmetic for the S-box, built from first principles.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = xtime(x);
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] t;
        t = {x, x} << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] inv;
        inv = 8'h00;
        if (b != 8'h00) begin
            inv = 8'h01;
            for (int i = 0; i < 254; i++) inv = gmul(inv, b);
        end
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [31:0] subWord(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // FIPS-197 key expansion; key is left-aligned in 256 bits.
    task automatic keyExpand(input logic [1:0] len, input logic [255:0] key);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        int nk;
        int nr;
        nr = (len == 2'b01) ? 12 : (len == 2'b10) ? 14 : 10;
        nk = nr - 6;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
        rc = 8'h01;
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = subWord({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xtime(rc);
            end else if (nk > 6 && i % nk == 4) begin
                t = subWord(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r <= nr; r++) rkModel[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        curNr = nr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkIdleOutputs(input string tag, input logic expKeys);
        checkOutput({tag, "_valid"}, 128'(rk_valid), 128'(0));
        checkOutput({tag, "_out"}, rk_out, 128'(0));
        checkOutput({tag, "_round"}, 128'(rk_round), 128'(0));
        checkOutput({tag, "_last"}, 128'(rk_last), 128'(0));
        checkOutput({tag, "_keys"}, 128'(keys_ready), 128'(expKeys));
    endtask

    // New-key pulse with a junk beat alongside it that must not be stored.
    task automatic startKey(input logic [1:0] len);
        key_flag = 1'b1;
        leng_key = len;
        wi_valid = 1'b1;
        {wi_0, wi_1, wi_2, wi_3} = {$urandom, $urandom, $urandom, $urandom};
        tick();
        key_flag = 1'b0;
        wi_valid = 1'b0;
        checkOutput("load_busy", 128'(busy), 128'(1));
        checkOutput("load_keys_clr", 128'(keys_ready), 128'(0));
        checkOutput("load_no_valid", 128'(rk_valid), 128'(0));
    endtask

    // Feeds nBeats model keys, optionally gapped, optionally raising dec_start mid-load.
    task automatic applyStimulus(input int nBeats, input bit gapped, input int decFrom, input int decTo);
        for (int i = 0; i < nBeats; i++) begin
            wi_valid  = 1'b1;
            {wi_0, wi_1, wi_2, wi_3} = rkModel[i];
            dec_start = (i >= decFrom && i <= decTo);
            tick();
            checkOutput("load_rk_valid", 128'(rk_valid), 128'(0));
            checkOutput("load_keys_ready", 128'(keys_ready), 128'(i == curNr));
            checkOutput("load_busy_beat", 128'(busy), 128'(i != curNr));
            if (gapped) begin
                wi_valid = 1'b0;
                {wi_0, wi_1, wi_2, wi_3} = {$urandom, $urandom, $urandom, $urandom};
                tick();
                checkOutput("gap_rk_valid", 128'(rk_valid), 128'(0));
            end
        end
        wi_valid  = 1'b0;
        dec_start = 1'b0;
    endtask

    task automatic playAndCheck(input int nr, input int stallRound, input bit randReady,
                                input bit chkFirst, input logic [127:0] expFirst);
        int got;
        int cyc;
        int stall;
        bit rdy;
        rk_ready  = 1'b0;
        dec_start = 1'b1;
        tick();
        dec_start = 1'b0;
        checkOutput("valid_rise", 128'(rk_valid), 128'(1));
        if (chkFirst) begin
            checkOutput("first_key", rk_out, expFirst);
            checkOutput("first_round", 128'(rk_round), 128'(nr));
        end
        got   = 0;
        cyc   = 0;
        stall = 0;
        while (got <= nr && cyc < 400) begin
            if (nr - got == stallRound && stall < 3) begin
                rdy = 1'b0;
                stall++;
            end else if (randReady) begin
                rdy = ($urandom_range(0, 3) != 0);
            end else begin
                rdy = 1'b1;
            end
            rk_ready = rdy;
            checkOutput("play_valid", 128'(rk_valid), 128'(1));
            checkOutput("play_round", 128'(rk_round), 128'(nr - got));
            checkOutput("play_key", rk_out, rkModel[nr - got]);
            checkOutput("play_last", 128'(rk_last), 128'(got == nr));
            if (rdy) got++;
            tick();
            cyc++;
        end
        rk_ready = 1'b0;
        checkOutput("all_beats", 128'(got), 128'(nr + 1));
        checkOutput("valid_drop", 128'(rk_valid), 128'(0));
        checkOutput("keys_kept", 128'(keys_ready), 128'(1));
        checkOutput("ready_not_busy", 128'(busy), 128'(0));
    endtask

    initial begin
        int cyc;
        rst_n     = 1'b0;
        key_flag  = 1'b0;
        leng_key  = 2'b00;
        wi_valid  = 1'b0;
        {wi_0, wi_1, wi_2, wi_3} = '0;
        dec_start = 1'b0;
        rk_ready  = 1'b0;

        // Reset state
        tick();
        tick();
        checkIdleOutputs("reset", 1'b0);
        checkOutput("reset_busy", 128'(busy), 128'(0));
        rst_n = 1'b1;
        tick();

        // 128-bit known-answer schedule
        keyExpand(2'b00, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0});
        startKey(2'b00);
        applyStimulus(11, 1'b0, -1, -1);
        wi_valid = 1'b1;
        {wi_0, wi_1, wi_2, wi_3} = {$urandom, $urandom, $urandom, $urandom};
        tick();
        wi_valid = 1'b0;
        playAndCheck(10, -1, 1'b0, 1'b1, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        checkOutput("key0_is_cipher_key", rkModel[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);

        // Back-to-back replays under random backpressure
        playAndCheck(10, -1, 1'b1, 1'b1, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        playAndCheck(10, -1, 1'b1, 1'b1, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // Code 11 behaves as 128-bit; dec_start during load is ignored
        keyExpand(2'b00, {$urandom, $urandom, $urandom, $urandom, 128'h0});
        startKey(2'b11);
        applyStimulus(11, 1'b0, 2, 5);
        playAndCheck(10, -1, 1'b0, 1'b0, '0);

        // 256-bit FIPS-197 key
        keyExpand(2'b10, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4);
        startKey(2'b10);
        applyStimulus(15, 1'b0, -1, -1);
        playAndCheck(14, -1, 1'b1, 1'b1, 128'hfe4890d1e6188d0b046df344706c631e);

        // 192-bit random key, gapped input, stall on round 7
        keyExpand(2'b01, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, 64'h0});
        startKey(2'b01);
        applyStimulus(13, 1'b1, -1, -1);
        playAndCheck(12, 7, 1'b0, 1'b0, '0);

        // Abort playback at round 5 with a new key
        dec_start = 1'b1;
        tick();
        dec_start = 1'b0;
        rk_ready  = 1'b1;
        cyc = 0;
        while (rk_round !== 4'd5 && cyc < 40) begin
            tick();
            cyc++;
        end
        checkOutput("abort_at_round5", 128'(rk_round), 128'(5));
        rk_ready = 1'b0;
        keyExpand(2'b10, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
        key_flag = 1'b1;
        leng_key = 2'b10;
        tick();
        key_flag = 1'b0;
        checkOutput("abort_valid", 128'(rk_valid), 128'(0));
        checkOutput("abort_keys", 128'(keys_ready), 128'(0));
        checkOutput("abort_busy", 128'(busy), 128'(1));

        // Reset in the middle of a load
        applyStimulus(6, 1'b0, -1, -1);
        #2;
        rst_n = 1'b0;
        #1;
        checkIdleOutputs("rst_load", 1'b0);
        checkOutput("rst_load_busy", 128'(busy), 128'(0));
        #2;
        rst_n = 1'b1;
        tick();
        checkIdleOutputs("post_rst", 1'b0);
        checkOutput("post_rst_busy", 128'(busy), 128'(0));

        // Reset in the middle of a playback
        keyExpand(2'b00, {$urandom, $urandom, $urandom, $urandom, 128'h0});
        startKey(2'b00);
        applyStimulus(11, 1'b0, -1, -1);
        dec_start = 1'b1;
        tick();
        dec_start = 1'b0;
        rk_ready  = 1'b1;
        tick();
        tick();
        checkOutput("pre_rst_round", 128'(rk_round), 128'(8));
        #2;
        rst_n = 1'b0;
        #1;
        checkIdleOutputs("rst_play", 1'b0);
        checkOutput("rst_play_busy", 128'(busy), 128'(0));
        rk_ready = 1'b0;
        #2;
        rst_n = 1'b1;
        dec_start = 1'b1;
        tick();
        dec_start = 1'b0;
        checkOutput("idle_no_play", 128'(rk_valid), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
